// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        KILL
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry holding register between the fetch port and decode.
module fetch_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    input  logic        consume,
    input  logic        flush,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    // A flush wins over a same-cycle refill; a refill wins over a consume,
    // since the new entry replaces the one decode is taking.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            instr    <= 32'h0;
            instr_pc <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= load_instr;
            instr_pc <= load_pc;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: drives the PC register, issues one instruction-memory
// request at a time and applies redirects/traps to the fetch stream.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_q,
    input  logic [31:0] pc_plus1,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap,
    input  logic        stall
);

    fetch_state_t state;
    logic         outstanding;
    logic [31:0]  pend_target;

    logic         redirect_any;
    logic [31:0]  target;
    logic         can_issue;
    logic         buf_load;
    logic         buf_flush;
    logic         buf_consume;

    assign redirect_any = trap | redirect_valid;
    assign target       = trap ? TRAP_VECTOR : redirect_target;
    assign can_issue    = !stall && (!instr_valid || instr_ready);
    assign buf_consume  = instr_valid && instr_ready;
    assign imem_addr    = pc_q;

    // Holding pc_q keeps imem_addr stable while a request waits for its ack;
    // a redirect against a waiting request is deferred through KILL.
    always_comb begin
        imem_req  = 1'b0;
        pc_next   = pc_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        if (rst) begin
            pc_next = RESET_VECTOR;
        end else begin
            case (state)
                BOOT: begin
                    pc_next = RESET_VECTOR;
                end
                FETCH: begin
                    imem_req = can_issue || outstanding;
                    if (redirect_any) begin
                        buf_flush = 1'b1;
                        if (!imem_req || imem_ack) begin
                            pc_next = target;
                        end
                    end else if (imem_req && imem_ack) begin
                        pc_next  = pc_plus1;
                        buf_load = 1'b1;
                    end
                end
                KILL: begin
                    imem_req  = 1'b1;
                    buf_flush = redirect_any;
                    if (imem_ack) begin
                        pc_next = redirect_any ? target : pend_target;
                    end
                end
                default: begin
                    pc_next = RESET_VECTOR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            outstanding <= 1'b0;
            pend_target <= RESET_VECTOR;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (redirect_any && imem_req && !imem_ack) begin
                        state       <= KILL;
                        pend_target <= target;
                        outstanding <= 1'b0;
                    end else begin
                        outstanding <= imem_req && !imem_ack && !redirect_any;
                    end
                end
                KILL: begin
                    if (redirect_any) begin
                        pend_target <= target;
                    end
                    if (imem_ack) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .load_instr (imem_rdata),
        .load_pc    (pc_q),
        .consume    (buf_consume),
        .flush      (buf_flush),
        .valid      (instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic
// checked every cycle against a behavioural fetch model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q = 32'h0;
    logic [31:0] pc_plus1;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap;
    logic        stall;

    int total = 0;
    int bad   = 0;
    logic model_on = 1'b0;

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .pc_q            (pc_q),
        .pc_plus1        (pc_plus1),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .stall           (stall)
    );

    always #5 clk = ~clk;

    // The PC register the sequencer drives, loading pc_next every cycle.
    always @(posedge clk) pc_q <= pc_next;
    assign pc_plus1 = pc_q + 32'd1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic rdy, input logic rv,
                                 input logic [31:0] tgt, input logic tr, input logic ack,
                                 input logic [31:0] data);
        @(posedge clk);
        #1;
        rst             = r;
        stall           = s;
        instr_ready     = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        trap            = tr;
        imem_ack        = ack;
        imem_rdata      = data;
    endtask

    // Behavioural model: tracks whether a response is in flight, whether it
    // must be discarded, where to go once it returns, and the buffered word.
    logic        m_boot = 1'b1, m_inflight = 1'b0, m_discard = 1'b0;
    logic        m_valid = 1'b0, m_fresh = 1'b1;
    logic [31:0] m_pend = 32'h0, m_instr = 32'h0, m_pc = 32'h0;
    logic        e_req, redir, consume;
    logic [31:0] e_next, tgt_m;

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                checkOutput("instr_valid", 32'(instr_valid), 32'(m_valid));
                if (m_valid || m_fresh) begin
                    checkOutput("instr", instr, m_instr);
                    checkOutput("instr_pc", instr_pc, m_pc);
                end
                if (rst) begin
                    m_boot = 1'b1; m_inflight = 1'b0; m_discard = 1'b0;
                    m_valid = 1'b0; m_fresh = 1'b1; m_instr = 32'h0; m_pc = 32'h0;
                end else if (m_boot) begin
                    checkOutput("boot_req", 32'(imem_req), 32'd0);
                    checkOutput("boot_pc_next", pc_next, 32'h0);
                    m_boot = 1'b0;
                end else begin
                    redir   = trap || redirect_valid;
                    tgt_m   = trap ? 32'h40 : redirect_target;
                    consume = m_valid && instr_ready;
                    if (m_discard) begin
                        e_req = 1'b1;
                        if (imem_ack) begin
                            e_next = redir ? tgt_m : m_pend;
                            m_discard = 1'b0;
                        end else begin
                            e_next = pc_q;
                            if (redir) m_pend = tgt_m;
                        end
                        if (redir || consume) m_valid = 1'b0;
                    end else begin
                        e_req = m_inflight || (!stall && (!m_valid || instr_ready));
                        if (redir) begin
                            m_valid = 1'b0;
                            if (e_req && !imem_ack) begin
                                e_next = pc_q;
                                m_discard = 1'b1;
                                m_pend = tgt_m;
                            end else begin
                                e_next = tgt_m;
                            end
                            m_inflight = 1'b0;
                        end else if (e_req && imem_ack) begin
                            e_next = pc_q + 32'd1;
                            m_valid = 1'b1; m_fresh = 1'b0;
                            m_instr = imem_rdata; m_pc = pc_q;
                            m_inflight = 1'b0;
                        end else begin
                            e_next = pc_q;
                            m_inflight = e_req;
                            if (consume) m_valid = 1'b0;
                        end
                    end
                    checkOutput("imem_req", 32'(imem_req), 32'(e_req));
                    checkOutput("pc_next", pc_next, e_next);
                    if (e_req) checkOutput("imem_addr", imem_addr, pc_q);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; trap = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        model_on = 1'b1;

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_pc_next", pc_next, 32'h0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);

        // Zero-wait memory: one fetch per cycle from address 0.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC0DE_0000 + 32'(i));
            @(negedge clk);
            checkOutput("seq_addr", imem_addr, 32'(i));
            checkOutput("seq_req", 32'(imem_req), 32'd1);
            checkOutput("seq_pc_next", pc_next, 32'(i + 1));
            if (i >= 1) begin
                checkOutput("seq_valid", 32'(instr_valid), 32'd1);
                checkOutput("seq_instr", instr, 32'hC0DE_0000 + 32'(i - 1));
                checkOutput("seq_instr_pc", instr_pc, 32'(i - 1));
            end
        end

        // Slow ack at address 5: address held for three cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, (i == 2), 32'hBEEF_0005);
            @(negedge clk);
            checkOutput("wait_addr", imem_addr, 32'h5);
            checkOutput("wait_pc_next", pc_next, (i == 2) ? 32'h6 : 32'h5);
        end

        // Decode back-pressure with a full buffer blocks new requests.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            checkOutput("bp_valid", 32'(instr_valid), 32'd1);
            checkOutput("bp_instr_pc", instr_pc, 32'h5);
            checkOutput("bp_instr", instr, 32'hBEEF_0005);
            checkOutput("bp_req", 32'(imem_req), 32'd0);
            checkOutput("bp_pc_next", pc_next, 32'h6);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_0006);
        @(negedge clk);
        checkOutput("resume_req", 32'(imem_req), 32'd1);
        checkOutput("resume_addr", imem_addr, 32'h6);
        checkOutput("resume_pc_next", pc_next, 32'h7);

        // Redirect to 0x100 while the request at 7 waits.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("pre_kill_addr", imem_addr, 32'h7);
        checkOutput("pre_kill_instr_pc", instr_pc, 32'h6);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("kill_entry_req", 32'(imem_req), 32'd1);
        checkOutput("kill_entry_pc_next", pc_next, 32'h7);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0007);
        @(negedge clk);
        checkOutput("kill_req", 32'(imem_req), 32'd1);
        checkOutput("kill_addr", imem_addr, 32'h7);
        checkOutput("kill_pc_next", pc_next, 32'h100);

        // Trap and redirect together: trap vector wins.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'hAAAA_0100);
        @(negedge clk);
        checkOutput("post_kill_addr", imem_addr, 32'h100);
        checkOutput("post_kill_valid", 32'(instr_valid), 32'd0);
        checkOutput("trap_pc_next", pc_next, 32'h40);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("trap_addr", imem_addr, 32'h40);
        checkOutput("trap_req", 32'(imem_req), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("midrst_pc_next", pc_next, 32'h0);
        checkOutput("midrst_req", 32'(imem_req), 32'd0);
        checkOutput("midrst_valid", 32'(instr_valid), 32'd0);

        // Randomized traffic; targets near the top of the space exercise wrap.
        for (int n = 0; n < 4000; n++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                          ($urandom_range(0, 19) == 0), 1'b0, $urandom);
            #1;
            imem_ack = imem_req && ($urandom_range(0, 2) != 0);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch controller that sequences the word-addressed program counter register and the instruction-memory port. It drives the PC register's next-value input every cycle and issues one outstanding instruction-memory request at a time. It buffers one fetched instruction toward decode and applies branch/jump redirects and trap entry with fixed priority. It sits between the PC register, instruction memory and the decode stage.

## Interface
- RESET_VECTOR, 32'h0000_0000, word address loaded after reset
- TRAP_VECTOR, 32'h0000_0040, word address loaded on trap
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_q  in  32  current PC register value
- pc_plus1  in  32  PC register value + 1 (word increment)
- pc_next  out  32  next value for PC register (PC register loads every cycle)
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  request word address (= pc_q)
- imem_ack  in  1  request completes this cycle; imem_rdata valid
- imem_rdata  in  32  fetched instruction
- instr_valid  out  1  buffered instruction valid to decode
- instr  out  32  buffered instruction
- instr_pc  out  32  word address of buffered instruction
- instr_ready  in  1  decode consumes instruction when instr_valid && instr_ready
- redirect_valid  in  1  branch/jump taken
- redirect_target  in  32  redirect word address
- trap  in  1  trap entry request
- stall  in  1  suppress new requests

## Operation
- States: BOOT, FETCH, KILL.
- BOOT: entered while rst=1; imem_req=0; pc_next=RESET_VECTOR; leaves to FETCH on first cycle with rst=0.
- FETCH: can_issue = !stall && (!instr_valid || instr_ready). imem_req=1 if can_issue or a request is already outstanding.
- Request rule: once imem_req rises it stays high with imem_addr unchanged until imem_ack; stall never withdraws an issued request.
- Ack with no redirect/trap: rdata -> instr, pc_q -> instr_pc, instr_valid=1 next cycle; pc_next=pc_plus1.
- No ack, no redirect: pc_next=pc_q (hold).
- Redirect target: trap -> TRAP_VECTOR, else redirect_valid -> redirect_target; trap wins when both high.
- Redirect, no request outstanding or ack this cycle: pc_next=target; acked data dropped; instr_valid cleared next cycle.
- Redirect while request outstanding without ack: latch target into pend_target, go KILL; pc_next=pc_q.
- KILL: imem_req held; on ack drop data, pc_next=pend_target, -> FETCH. New redirect/trap in KILL overwrites pend_target (latest wins; trap over redirect same cycle).
- Buffer consumed with no refill: instr_valid=0 next cycle.

## Timing
- Reset values: pc_next=RESET_VECTOR, imem_req=0, instr_valid=0, instr=0, instr_pc=0, state BOOT.
- rst mid-operation: outstanding request abandoned, buffer flushed, all outputs to reset values the next cycle; memory side must tolerate dropped request.
- Fetch latency: req to instr_valid = ack latency + 1 cycle; zero-wait memory (ack same cycle as req) gives one instruction per cycle with instr_ready held high.
- Redirect to first request at new address: 1 cycle (PC register load); plus remaining ack wait when in KILL.
- pc_next, imem_req, imem_addr combinational from state, pc_q and inputs; instr, instr_pc, instr_valid, pend_target registered.
- Address arithmetic modulo 2^32; pc_plus1 wrap from 32'hFFFF_FFFF to 0 accepted without flag.

## Structure
- Package fetch_pkg: enum fetch_state_t {BOOT, FETCH, KILL}; no other shared types.
- One sub-module fetch_buffer: single-entry instr/instr_pc/valid register with load, consume and flush.

## Test plan
- Reset release, zero-wait memory, instr_ready=1 -> imem_addr 0,1,2,3 on consecutive cycles; instr_valid from cycle 2.
- Ack after 3 cycles at pc 5 -> imem_addr stable 5 for 3 cycles, pc_next=5 then 6; instr_pc=5.
- instr_ready=0 with buffer full -> imem_req=0, pc_next=pc_q; release -> fetch resumes at next address.
- redirect_valid to 32'h100 during outstanding request at 7 -> KILL, data for 7 dropped, next imem_addr=32'h100.
- trap and redirect_valid (target 32'h80) same cycle -> pc_next=32'h40; rst asserted mid-wait -> pc_next=0, imem_req=0, instr_valid=0 next cycle.
